uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter UART_BPS, default 'd9600, meaning the serial bit rate in bits/s.
REQ-002 The block SHALL have parameter CLK_FREQ, default 'd50_000_000, meaning the sys_clk frequency in Hz.
REQ-003 The block SHALL have port sys_clk, input, 1 bit, system clock; all logic is rising-edge.
REQ-004 The block SHALL have port sys_rst_n, input, 1 bit, reset: asynchronous, active-low.
REQ-005 The block SHALL have port rx, input, 1 bit, asynchronous serial line; idles high.
REQ-006 The block SHALL have port po_data, output, 8 bits, last correctly received byte.
REQ-007 The block SHALL have port po_flag, output, 1 bit, one-cycle pulse marking that po_data was just updated.
REQ-008 The block SHALL have port po_frame_err, output, 1 bit, one-cycle pulse marking a frame whose stop bit sampled 0.

Function
REQ-009 The block SHALL pass rx through a 2-flop synchronizer and a third flop used for edge detection; all decisions use synchronized rx only.
REQ-010 The block SHALL derive BAUD_CNT_MAX = CLK_FREQ/UART_BPS (5208 at defaults) and HALF = BAUD_CNT_MAX/2 (2604), using a 16-bit baud counter.
REQ-011 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-012 In IDLE, a synchronized falling edge SHALL move the FSM to START and clear the baud counter and the bit counter.
REQ-013 Outside IDLE, the baud counter SHALL count 0..BAUD_CNT_MAX-1 and wrap to 0; the sample decision occurs in the cycle where baud_cnt == HALF.
REQ-014 In START, if the decision is 1 (false start or glitch), the FSM SHALL return to IDLE with no output pulse; if the decision is 0, the FSM SHALL go to DATA.
REQ-015 In DATA, each decision SHALL be stored LSB first into a shift register, the bit counter SHALL increment 0..7, and after bit 7 the FSM SHALL go to STOP.
REQ-016 In STOP, on the decision cycle the FSM SHALL return to IDLE, so a new start edge is accepted from the middle of the stop bit onward.
REQ-017 If the stop decision is 1, po_data SHALL take the shift register value and po_flag SHALL be 1 for exactly one cycle, both registered on the cycle after the decision.
REQ-018 If the stop decision is 0, po_frame_err SHALL be 1 for exactly one cycle on the cycle after the decision, and po_data SHALL be unchanged.
REQ-019 po_flag and po_frame_err SHALL never be asserted in the same cycle.
REQ-020 Falling edges on rx while the FSM is not in IDLE SHALL be ignored.
REQ-021 With rx held low continuously, the block SHALL produce one frame_err and then no further start until a rising and then a falling edge occur.

Reset
REQ-022 On sys_rst_n low, the block SHALL reset: FSM to IDLE; baud and bit counters to 0; shift register 0; po_data 8'h00; po_flag 0; po_frame_err 0; synchronizer flops 1.
REQ-023 Asserting reset mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait in IDLE for a fresh falling edge.

Configuration
REQ-024 The macro UART_RX_MAJORITY_EN SHALL select how each bit is sampled, as set out in REQ-025 and REQ-026.
REQ-025 With UART_RX_MAJORITY_EN defined, each decision SHALL be the 2-of-3 majority of synchronized rx sampled at baud_cnt == HALF-2, HALF-1 and HALF.
REQ-026 Without UART_RX_MAJORITY_EN, each decision SHALL be the single sample at baud_cnt == HALF; the majority logic SHALL be absent.
REQ-027 Decision timing and all outputs SHALL be identical in both configurations for clean input.

Verification (defaults, 5208 cycles/bit)
REQ-028 Clean frame 0x55 (start, 1,0,1,0,1,0,1,0, stop=1) -> po_data=8'h55, single po_flag pulse 49476 +/-4 cycles after the rx falling edge, po_frame_err stays 0.
REQ-029 rx low for 1000 cycles then high -> no po_flag and no po_frame_err; a following valid 0xA3 frame is received correctly.
REQ-030 Frame 0x3C with stop bit 0, after a prior 0x55 -> one po_frame_err pulse, no po_flag, po_data remains 8'h55.
REQ-031 Back-to-back 0x00 then 0xFF with the second start edge immediately after the first stop bit -> two po_flag pulses, with data 8'h00 then 8'hFF.
REQ-032 sys_rst_n pulsed low during bit 4 of a frame -> outputs at reset values, no pulses; the next clean frame 0x81 is received correctly.
REQ-033 With UART_RX_MAJORITY_EN, 0x0F with a 1-cycle inverted glitch at baud_cnt == HALF of bit 2 -> po_data=8'h0F; without the macro, the same stimulus -> po_data=8'h0B.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx #(
    parameter int UART_BPS = 'd9600,
    parameter int CLK_FREQ = 'd50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       po_frame_err
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF         = BAUD_CNT_MAX / 2;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] HALF_CNT  = 16'(HALF);

    // state | meaning
    // IDLE  | line idle, waiting for a synchronized falling edge
    // START | timing the start bit, centre sample rejects glitches
    // DATA  | shifting in 8 data bits LSB first
    // STOP  | checking the stop bit, flag or frame error on its centre
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  po_data_q, po_data_d;
    logic        po_flag_q, po_flag_d;
    logic        po_frame_err_q, po_frame_err_d;
    logic        rx_fall;
    logic        sample_pt;
    logic        bit_val;

    assign rx_fall   = rx_s3_q & ~rx_s2_q;
    assign sample_pt = (baud_cnt_q == HALF_CNT);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] EARLY0_CNT = 16'(HALF - 2);
    localparam logic [15:0] EARLY1_CNT = 16'(HALF - 1);

    logic [1:0] early_q, early_d;

    always_comb begin
        early_d = early_q;
        if (state_q != IDLE) begin
            if (baud_cnt_q == EARLY0_CNT) early_d[0] = rx_s2_q;
            if (baud_cnt_q == EARLY1_CNT) early_d[1] = rx_s2_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) early_q <= 2'b11;
        else            early_q <= early_d;
    end

    assign bit_val = (early_q[0] & early_q[1]) | (early_q[0] & rx_s2_q) | (early_q[1] & rx_s2_q);
`else
    assign bit_val = rx_s2_q;
`endif

    always_comb begin
        state_d        = state_q;
        baud_cnt_d     = (baud_cnt_q == BAUD_LAST) ? 16'd0 : baud_cnt_q + 16'd1;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        po_data_d      = po_data_q;
        po_flag_d      = 1'b0;
        po_frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                baud_cnt_d = 16'd0;
                if (rx_fall) begin
                    state_d   = START;
                    bit_cnt_d = 3'd0;
                end
            end
            START: begin
                if (sample_pt) state_d = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d   = {bit_val, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                if (sample_pt) begin
                    state_d = IDLE;
                    if (bit_val) begin
                        po_data_d = shift_q;
                        po_flag_d = 1'b1;
                    end else begin
                        po_frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            rx_s1_q        <= 1'b1;
            rx_s2_q        <= 1'b1;
            rx_s3_q        <= 1'b1;
            baud_cnt_q     <= 16'd0;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            po_data_q      <= 8'h00;
            po_flag_q      <= 1'b0;
            po_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_s1_q        <= rx;
            rx_s2_q        <= rx_s1_q;
            rx_s3_q        <= rx_s2_q;
            baud_cnt_q     <= baud_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            po_data_q      <= po_data_d;
            po_flag_q      <= po_flag_d;
            po_frame_err_q <= po_frame_err_d;
        end
    end

    assign po_data      = po_data_q;
    assign po_flag      = po_flag_q;
    assign po_frame_err = po_frame_err_q;

endmodule
